// File: rtl/fuzzy_pkg.sv
// Shared types for the fuzzy membership-function evaluator: slot parameters,
// controller states and the parameter ordering rule.
package fuzzy_pkg;

    localparam int DEF_NUM_IN = 2;
    localparam int DEF_NUM_MF = 3;

    // Trapezoid corners, signed Q7.0, a in the most significant byte.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } mf_param_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic mf_ordered(input mf_param_t p);
        return ($signed(p.a) <= $signed(p.b)) &&
               ($signed(p.b) <= $signed(p.c)) &&
               ($signed(p.c) <= $signed(p.d));
    endfunction

endpackage

// File: rtl/mf_eval_ctrl_trap.sv
// Combinational trapezoid membership evaluator: Q7.0 input and corners in,
// Q1.15 degree out (0 outside (a,d), 0x7FFF on the [b,c] plateau).
module mf_eval_ctrl_trap
    import fuzzy_pkg::*;
(
    input  logic [7:0]  x_i,
    input  mf_param_t   p_i,
    output logic [15:0] mu_o
);

    localparam logic [15:0] MU_ONE = 16'h7FFF;

    logic signed [8:0] xs, as, bs, cs, ds;
    logic [8:0]        num, den;
    logic [15:0]       ratio;
    logic              use_ratio, full;

    assign xs = {x_i[7], x_i};
    assign as = {p_i.a[7], p_i.a};
    assign bs = {p_i.b[7], p_i.b};
    assign cs = {p_i.c[7], p_i.c};
    assign ds = {p_i.d[7], p_i.d};

    // Open interval (a,d) so an all-zero slot yields 0 for every x.
    always_comb begin
        num       = '0;
        den       = 9'd1;
        use_ratio = 1'b0;
        full      = 1'b0;
        if ((xs > as) && (xs < ds)) begin
            if (xs < bs) begin
                num       = 9'(xs - as);
                den       = 9'(bs - as);
                use_ratio = 1'b1;
            end else if (xs > cs) begin
                num       = 9'(ds - xs);
                den       = 9'(ds - cs);
                use_ratio = 1'b1;
            end else begin
                full = 1'b1;
            end
        end
    end

    // num < den on the slopes, so the quotient always fits in 15 bits.
    assign ratio = 16'({num, 15'b0} / {15'b0, den});
    assign mu_o  = full ? MU_ONE : (use_ratio ? ratio : 16'h0000);

endmodule

// File: rtl/mf_eval_ctrl.sv
// Frame controller: latches crisp inputs, walks every MF slot through one
// shared trapezoid evaluator and holds the degrees until the consumer takes them.
module mf_eval_ctrl
    import fuzzy_pkg::*;
#(
    parameter  int NUM_IN = DEF_NUM_IN,
    parameter  int NUM_MF = DEF_NUM_MF,
    localparam int NMF    = NUM_IN * NUM_MF,
    localparam int AW     = (NMF > 1) ? $clog2(NMF) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [31:0]           cfg_data,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_IN*8-1:0]   x_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NMF*16-1:0]     mu_out
);

    // state | meaning
    // IDLE  | accepts config writes and new frames
    // EVAL  | one slot per cycle through the evaluator
    // DONE  | results held with out_valid until out_ready

    state_e               state_q;
    logic [AW-1:0]        k_q;
    logic [NUM_IN*8-1:0]  x_q;
    mf_param_t            params_q [NMF];
    logic [NMF*16-1:0]    mu_q;
    logic                 out_valid_q;
    logic                 cfg_err_q;

    mf_param_t            cur_p;
    logic [7:0]           cur_x;
    logic [15:0]          cur_mu;
    mf_param_t            wr_p;
    logic                 wr_addr_ok;

    always_comb begin
        cur_p = '0;
        cur_x = '0;
        for (int s = 0; s < NMF; s++) begin
            if (k_q == AW'(s)) begin
                cur_p = params_q[s];
                cur_x = x_q[8*(s/NUM_MF) +: 8];
            end
        end
    end

    assign wr_p       = mf_param_t'(cfg_data);
    assign wr_addr_ok = (int'(cfg_addr) < NMF);

    mf_eval_ctrl_trap u_trap (
        .x_i  (cur_x),
        .p_i  (cur_p),
        .mu_o (cur_mu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            x_q         <= '0;
            mu_q        <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int s = 0; s < NMF; s++) begin
                params_q[s] <= '0;
            end
        end else begin
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A write in the accept cycle lands before slot 0 is read.
                    if (cfg_we) begin
                        if (wr_addr_ok && mf_ordered(wr_p)) begin
                            for (int s = 0; s < NMF; s++) begin
                                if (cfg_addr == AW'(s)) begin
                                    params_q[s] <= wr_p;
                                end
                            end
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    if (in_valid) begin
                        x_q     <= x_in;
                        k_q     <= '0;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    for (int s = 0; s < NMF; s++) begin
                        if (k_q == AW'(s)) begin
                            mu_q[16*s +: 16] <= cur_mu;
                        end
                    end
                    if (k_q == AW'(NMF - 1)) begin
                        k_q         <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign cfg_ready = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign cfg_err   = cfg_err_q;
    assign mu_out    = mu_q;

endmodule

// File: tb/tb_mf_eval_ctrl.sv
// Self-checking bench for mf_eval_ctrl against a trapezoid reference model.
module tb_mf_eval_ctrl;

    localparam int NUM_IN = 2;
    localparam int NUM_MF = 3;
    localparam int NMF    = NUM_IN * NUM_MF;
    localparam int AW     = $clog2(NMF);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic [31:0]          cfg_data;
    logic                 cfg_ready;
    logic                 cfg_err;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_IN*8-1:0]  x_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [NMF*16-1:0]    mu_out;

    int total = 0;
    int bad   = 0;

    int ma [NMF];
    int mb [NMF];
    int mc [NMF];
    int md [NMF];
    int mx [NUM_IN];
    logic [15:0] got_mu [NMF];

    always #5 clk = ~clk;

    mf_eval_ctrl #(.NUM_IN(NUM_IN), .NUM_MF(NUM_MF)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mu_out    (mu_out)
    );

    // Degree of membership as a fraction of full scale, floored to Q1.15.
    function automatic int mu_ref(int x, int a, int b, int c, int d);
        if (x <= a || x >= d) return 0;
        if (x < b) return ((x - a) * 32768) / (b - a);
        if (x > c) return ((d - x) * 32768) / (d - c);
        return 32767;
    endfunction

    function automatic logic [15:0] exp_mu(int s);
        return 16'(mu_ref(mx[s / NUM_MF], ma[s], mb[s], mc[s], md[s]));
    endfunction

    function automatic int rnd8();
        logic [7:0] r;
        r = 8'($urandom);
        return int'($signed(r));
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NMF; s++) begin
            ma[s] = 0; mb[s] = 0; mc[s] = 0; md[s] = 0;
        end
    endtask

    task automatic do_write(input int addr, input int a, input int b, input int c,
                            input int d, output bit exp_err);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = {8'(a), 8'(b), 8'(c), 8'(d)};
        exp_err  = !(addr < NMF && a <= b && b <= c && c <= d);
        if (!exp_err) begin
            ma[addr] = a; mb[addr] = b; mc[addr] = c; md[addr] = d;
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_x(input int x0, input int x1);
        mx[0] = x0;
        mx[1] = x1;
        x_in  = {8'(x1), 8'(x0)};
    endtask

    task automatic launch(input int x0, input int x1);
        set_x(x0, x1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        for (int s = 0; s < NMF; s++) got_mu[s] = mu_out[16*s +: 16];
    endtask

    task automatic rel();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input int x0, input int x1, output bit ok);
        launch(x0, x1);
        wait_out(ok);
        rel();
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; x_in = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        total++; if (mu_out !== '0) begin bad++; $display("FAIL reset_mu_out got=%h exp=0", mu_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit e, ok;
        int xs [3];
        logic [15:0] want [3];
        xs[0] = 0;   want[0] = 16'h7FFF;
        xs[1] = -48; want[1] = 16'h4000;
        xs[2] = 100; want[2] = 16'h0000;
        do_write(0, -64, -32, 32, 64, e);
        @(negedge clk);
        total++; if (cfg_err !== e) begin bad++; $display("FAIL basic_cfg_err got=%b exp=%b", cfg_err, e); end
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) begin
            run_frame(xs[t], rnd8(), ok);
            total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=0 exp=1"); end
            total++; if (got_mu[0] !== want[t]) begin bad++; $display("FAIL basic_slot0 x=%0d got=%h exp=%h", xs[t], got_mu[0], want[t]); end
            for (int s = 1; s < NMF; s++) begin
                total++; if (got_mu[s] !== exp_mu(s)) begin bad++; $display("FAIL basic_slot%0d got=%h exp=%h", s, got_mu[s], exp_mu(s)); end
            end
        end
    endtask

    task automatic test_latency();
        logic [NMF*16-1:0] snap;
        set_x(-20, 37);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < NMF; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early cyc=%0d got=%b exp=0", i, out_valid); end
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_first got=%b exp=1", out_valid); end
        snap = mu_out;
        for (int s = 0; s < NMF; s++) begin
            total++; if (snap[16*s +: 16] !== exp_mu(s)) begin bad++; $display("FAIL lat_slot%0d got=%h exp=%h", s, snap[16*s +: 16], exp_mu(s)); end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || mu_out !== snap || in_ready !== 1'b0) begin
                bad++; $display("FAIL lat_hold cyc=%0d got=%b/%b exp=1/0", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lat_release_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL lat_idle got=%b/%b exp=0/1", out_valid, in_ready); end
        total++; if (mu_out !== snap) begin bad++; $display("FAIL lat_idle_mu got=%h exp=%h", mu_out, snap); end
        @(posedge clk); #1;
    endtask

    task automatic test_cfg_err();
        bit e, ok;
        do_write(1, -20, -10, 10, 20, e);
        do_write(1, 10, 5, 20, 30, e);
        @(negedge clk);
        total++; if (cfg_err !== 1'b1 || e !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_once got=%b exp=0", cfg_err); end
        @(posedge clk); #1;
        for (int addr = NMF; addr < (1 << AW); addr++) begin
            do_write(addr, -5, 0, 0, 5, e);
            @(negedge clk);
            total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_addr%0d got=%b exp=1", addr, cfg_err); end
            @(posedge clk); #1;
        end
        run_frame(15, 3, ok);
        total++; if (!ok) begin bad++; $display("FAIL err_timeout got=0 exp=1"); end
        total++; if (got_mu[1] !== 16'h4000) begin bad++; $display("FAIL err_old_slot1 got=%h exp=4000", got_mu[1]); end
        for (int s = 0; s < NMF; s++) begin
            total++; if (got_mu[s] !== exp_mu(s)) begin bad++; $display("FAIL err_slot%0d got=%h exp=%h", s, got_mu[s], exp_mu(s)); end
        end
    endtask

    task automatic test_cfg_during_eval();
        bit e, ok;
        for (int s = 0; s < 4; s++) do_write(s, -100, -50, 50, 100, e);
        launch(0, 0);
        for (int i = 0; i < 4; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = AW'(i);
            cfg_data = (i % 2 == 0) ? 32'h00010203 : 32'h32281E14;
            @(negedge clk);
            total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL eval_wr_err cyc=%0d got=%b exp=0", i, cfg_err); end
            @(posedge clk); #1;
        end
        cfg_we = 1'b0;
        @(negedge clk);
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL eval_wr_err_last got=%b exp=0", cfg_err); end
        wait_out(ok);
        rel();
        total++; if (!ok) begin bad++; $display("FAIL eval_wr_timeout got=0 exp=1"); end
        for (int s = 0; s < NMF; s++) begin
            total++; if (got_mu[s] !== exp_mu(s)) begin bad++; $display("FAIL eval_wr_slot%0d got=%h exp=%h", s, got_mu[s], exp_mu(s)); end
        end
        run_frame(0, 0, ok);
        for (int s = 0; s < 4; s++) begin
            total++; if (got_mu[s] !== 16'h7FFF) begin bad++; $display("FAIL eval_wr_after_slot%0d got=%h exp=7fff", s, got_mu[s]); end
        end
    endtask

    task automatic test_coincident();
        bit ok;
        set_x(-75, 9);
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_data = {8'(-100), 8'(-50), 8'(50), 8'(100)};
        ma[0] = -100; mb[0] = -50; mc[0] = 50; md[0] = 100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        wait_out(ok);
        rel();
        total++; if (!ok) begin bad++; $display("FAIL coin_timeout got=0 exp=1"); end
        total++; if (got_mu[0] !== 16'h4000) begin bad++; $display("FAIL coin_slot0 got=%h exp=4000", got_mu[0]); end
        for (int s = 1; s < NMF; s++) begin
            total++; if (got_mu[s] !== exp_mu(s)) begin bad++; $display("FAIL coin_slot%0d got=%h exp=%h", s, got_mu[s], exp_mu(s)); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        launch(-30, 60);
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout got=0 exp=1"); end
        for (int s = 0; s < NMF; s++) begin
            total++; if (got_mu[s] !== exp_mu(s)) begin bad++; $display("FAIL b2b_first_slot%0d got=%h exp=%h", s, got_mu[s], exp_mu(s)); end
        end
        set_x(45, -45);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_done_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(ok);
        rel();
        total++; if (!ok) begin bad++; $display("FAIL b2b_second_timeout got=0 exp=1"); end
        for (int s = 0; s < NMF; s++) begin
            total++; if (got_mu[s] !== exp_mu(s)) begin bad++; $display("FAIL b2b_second_slot%0d got=%h exp=%h", s, got_mu[s], exp_mu(s)); end
        end
    endtask

    task automatic test_random();
        bit e, ok;
        int v [4];
        int addr, nw, tmp;
        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                addr = $urandom_range(0, NMF);
                for (int i = 0; i < 4; i++) v[i] = rnd8();
                if ($urandom_range(0, 3) != 0) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3 - i; j++)
                            if (v[j] > v[j+1]) begin tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp; end
                end
                do_write(addr, v[0], v[1], v[2], v[3], e);
                @(negedge clk);
                total++; if (cfg_err !== e) begin bad++; $display("FAIL rnd_cfg_err it=%0d got=%b exp=%b", it, cfg_err, e); end
                @(posedge clk); #1;
            end
            run_frame(rnd8(), rnd8(), ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd_timeout it=%0d got=0 exp=1", it); end
            for (int s = 0; s < NMF; s++) begin
                total++; if (got_mu[s] !== exp_mu(s)) begin bad++; $display("FAIL rnd_slot%0d it=%0d got=%h exp=%h", s, it, got_mu[s], exp_mu(s)); end
            end
        end
    endtask

    task automatic test_reset_mid_eval();
        bit e, ok;
        for (int s = 0; s < NMF; s++) do_write(s, -120, -60, 60, 120, e);
        launch(5, -5);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b/%b exp=1/1", in_ready, cfg_ready); end
        total++; if (mu_out !== '0) begin bad++; $display("FAIL rstmid_mu got=%h exp=0", mu_out); end
        @(posedge clk); #1;
        run_frame(5, -5, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=0 exp=1"); end
        for (int s = 0; s < NMF; s++) begin
            total++; if (got_mu[s] !== exp_mu(s) || got_mu[s] !== 16'h0000) begin bad++; $display("FAIL rstmid_slot%0d got=%h exp=0000", s, got_mu[s]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_cfg_err();
        test_cfg_during_eval();
        test_coincident();
        test_back_to_back();
        test_random();
        test_reset_mid_eval();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
